// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bundle between two result sources, the arbiter and the regfile write port.
// slave = arbiter side, master = source/regfile-observer side.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic                   s0_valid;
    logic                   s0_ready;
    logic [ADDR_W-1:0]      s0_rd_addr;
    logic [DATA_W-1:0]      s0_data;
    logic                   s1_valid;
    logic                   s1_ready;
    logic [ADDR_W-1:0]      s1_rd_addr;
    logic [DATA_W-1:0]      s1_data;
    logic                   rf_w_en;
    logic [ADDR_W-1:0]      rf_rd_addr;
    logic [DATA_W-1:0]      rf_w_data;
    logic [2**ADDR_W-1:0]   pending_mask;
    logic                   idle;

    modport slave (
        input  s0_valid, s0_rd_addr, s0_data,
        input  s1_valid, s1_rd_addr, s1_data,
        output s0_ready, s1_ready,
        output rf_w_en, rf_rd_addr, rf_w_data, pending_mask, idle
    );

    modport master (
        output s0_valid, s0_rd_addr, s0_data,
        output s1_valid, s1_rd_addr, s1_data,
        input  s0_ready, s1_ready,
        input  rf_w_en, rf_rd_addr, rf_w_data, pending_mask, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: two per-source writeback FIFOs, round-robin merged onto one registered regfile write port.
// Latency: push at edge E -> rf_w_en from edge E+1 when granted at once; one write per cycle total.
// Backpressure: sN_ready = FIFO not full (and out of reset); a full FIFO refuses a push even when popped.
module regfile_wb_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int              PW       = $clog2(DEPTH);
    localparam int              NREG     = 2**ADDR_W;
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    logic [1:0]          in_vld;
    logic [1:0]          in_rdy;
    logic [1:0]          push;
    logic [1:0]          grant;
    logic [1:0]          nonempty;
    logic [ADDR_W-1:0]   in_rd   [2];
    logic [DATA_W-1:0]   in_dat  [2];

    logic [ADDR_W-1:0]   mem_rd  [2][DEPTH];
    logic [DATA_W-1:0]   mem_dat [2][DEPTH];
    logic [PW-1:0]       wptr    [2];
    logic [PW-1:0]       rptr    [2];
    logic [PW:0]         cnt     [2];

    logic                rr_pref;
    logic                sel;
    logic [ADDR_W-1:0]   head_rd;
    logic [DATA_W-1:0]   head_dat;

    logic                rf_w_en_q;
    logic [ADDR_W-1:0]   rf_rd_addr_q;
    logic [DATA_W-1:0]   rf_w_data_q;
    logic [NREG-1:0]     mask;

    assign in_vld    = {bus.s1_valid, bus.s0_valid};
    assign in_rd[0]  = bus.s0_rd_addr;
    assign in_rd[1]  = bus.s1_rd_addr;
    assign in_dat[0] = bus.s0_data;
    assign in_dat[1] = bus.s1_data;

    always_comb begin
        nonempty = '0;
        in_rdy   = '0;
        push     = '0;
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (cnt[i] != '0);
            in_rdy[i]   = reset_n && (cnt[i] != CNT_FULL);
            push[i]     = in_vld[i] && in_rdy[i];
        end
    end

    // Contention goes to rr_pref; otherwise whichever head exists (at most one).
    assign grant    = (nonempty == 2'b11) ? (rr_pref ? 2'b10 : 2'b01) : nonempty;
    assign sel      = grant[1];
    assign head_rd  = mem_rd[sel][rptr[sel]];
    assign head_dat = mem_dat[sel][rptr[sel]];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_rd[i][wptr[i]]  <= in_rd[i];
                mem_dat[i][wptr[i]] <= in_dat[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i] <= '0;
                rptr[i] <= '0;
                cnt[i]  <= '0;
            end
            rr_pref      <= 1'b0;
            rf_w_en_q    <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_w_data_q  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i])  wptr[i] <= wptr[i] + PTR_ONE;
                if (grant[i]) rptr[i] <= rptr[i] + PTR_ONE;
                cnt[i] <= cnt[i] + {{PW{1'b0}}, push[i]} - {{PW{1'b0}}, grant[i]};
            end
            if (nonempty == 2'b11) rr_pref <= ~rr_pref;
            // x0 targets still take the slot but never raise the write enable.
            rf_w_en_q <= (|grant) && (head_rd != '0);
            if (|grant) begin
                rf_rd_addr_q <= head_rd;
                rf_w_data_q  <= head_dat;
            end
        end
    end

    always_comb begin
        mask = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((PW+1)'(k) < cnt[s]) mask[mem_rd[s][rptr[s] + PW'(k)]] = 1'b1;
            end
        end
        if (rf_w_en_q) mask[rf_rd_addr_q] = 1'b1;
        mask[0] = 1'b0;
    end

    assign bus.s0_ready     = in_rdy[0];
    assign bus.s1_ready     = in_rdy[1];
    assign bus.rf_w_en      = rf_w_en_q;
    assign bus.rf_rd_addr   = rf_rd_addr_q;
    assign bus.rf_w_data    = rf_w_data_q;
    assign bus.pending_mask = mask;
    assign bus.idle         = (nonempty == 2'b00) && !rf_w_en_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table of single writes plus sequences for contention,
// backpressure, async reset mid-flight and pointer wrap, all scored against per-source queues.
module tb_regfile_wb_arbiter;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          src;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exp_en;
        logic [31:0] exp_mask;
    } vec_t;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   cnt0;
    int   cnt1;

    wr_t  stim0[$];
    wr_t  stim1[$];
    wr_t  exp0[$];
    wr_t  exp1[$];
    logic [4:0] out_rd[$];
    int   out_cyc[$];

    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic load(input bit src, input logic [4:0] rd, input logic [31:0] data);
        wr_t w;
        w.rd   = rd;
        w.data = data;
        if (src) stim1.push_back(w);
        else     stim0.push_back(w);
    endtask

    task automatic wait_cnt(input bit src, input int target, input int budget);
        for (int c = 0; c < budget && (src ? cnt1 : cnt0) < target; c++) tick();
        chk(src ? "accept_s1" : "accept_s0", (src ? cnt1 : cnt0), target);
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget &&
             (stim0.size() != 0 || stim1.size() != 0 || exp0.size() != 0 ||
              exp1.size() != 0 || !bus.idle); c++) tick();
        chk("drain_exp0", exp0.size(), 0);
        chk("drain_exp1", exp1.size(), 0);
        chk("drain_idle", bus.idle, 1);
    endtask

    // Source driver: payload held until the handshake edge; accepted writes go to the scoreboard.
    initial begin
        bit  f0, f1;
        wr_t w;
        bus.s0_valid = 1'b0; bus.s0_rd_addr = '0; bus.s0_data = '0;
        bus.s1_valid = 1'b0; bus.s1_rd_addr = '0; bus.s1_data = '0;
        forever begin
            @(negedge clock);
            f0 = bus.s0_valid && bus.s0_ready;
            f1 = bus.s1_valid && bus.s1_ready;
            @(posedge clock);
            #1;
            if (f0 && stim0.size() != 0) begin
                w = stim0.pop_front();
                if (w.rd != 0) exp0.push_back(w);
                cnt0++;
            end
            if (f1 && stim1.size() != 0) begin
                w = stim1.pop_front();
                if (w.rd != 0) exp1.push_back(w);
                cnt1++;
            end
            bus.s0_valid = (stim0.size() != 0);
            if (stim0.size() != 0) begin
                bus.s0_rd_addr = stim0[0].rd;
                bus.s0_data    = stim0[0].data;
            end
            bus.s1_valid = (stim1.size() != 0);
            if (stim1.size() != 0) begin
                bus.s1_rd_addr = stim1[0].rd;
                bus.s1_data    = stim1[0].data;
            end
        end
    end

    // Every write must match the head of one source's queue and be flagged pending.
    always @(negedge clock) begin
        if (reset_n && bus.rf_w_en) begin
            out_rd.push_back(bus.rf_rd_addr);
            out_cyc.push_back(cyc);
            chk("mask_out_stage", bus.pending_mask[bus.rf_rd_addr], 1);
            n_checks++;
            if (exp0.size() != 0 && exp0[0].rd == bus.rf_rd_addr && exp0[0].data == bus.rf_w_data)
                void'(exp0.pop_front());
            else if (exp1.size() != 0 && exp1[0].rd == bus.rf_rd_addr && exp1[0].data == bus.rf_w_data)
                void'(exp1.pop_front());
            else begin
                n_errors++;
                $display("FAIL scoreboard: got rd=%0d data=%0h, no source head matches",
                         bus.rf_rd_addr, bus.rf_w_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[6];
        logic [4:0] cont_exp[8];
        int         base;

        vecs[0] = '{src: 1'b0, rd: 5'd5,  data: 32'hDEADBEEF, exp_en: 1'b1, exp_mask: 32'h0000_0020};
        vecs[1] = '{src: 1'b1, rd: 5'd31, data: 32'hCAFE_0031, exp_en: 1'b1, exp_mask: 32'h8000_0000};
        vecs[2] = '{src: 1'b0, rd: 5'd0,  data: 32'h0000_1234, exp_en: 1'b0, exp_mask: 32'h0000_0000};
        vecs[3] = '{src: 1'b1, rd: 5'd0,  data: 32'h5555_AAAA, exp_en: 1'b0, exp_mask: 32'h0000_0000};
        vecs[4] = '{src: 1'b1, rd: 5'd17, data: 32'h0017_0017, exp_en: 1'b1, exp_mask: 32'h0002_0000};
        vecs[5] = '{src: 1'b0, rd: 5'd1,  data: 32'hFFFF_FFFF, exp_en: 1'b1, exp_mask: 32'h0000_0002};

        cont_exp[0] = 5'd1;  cont_exp[1] = 5'd11; cont_exp[2] = 5'd2; cont_exp[3] = 5'd12;
        cont_exp[4] = 5'd3;  cont_exp[5] = 5'd13; cont_exp[6] = 5'd4; cont_exp[7] = 5'd14;

        n_checks = 0; n_errors = 0; cyc = 0; cnt0 = 0; cnt1 = 0;
        reset_n = 1'b0;
        #3;
        chk("rst_s0_ready", bus.s0_ready, 0);
        chk("rst_s1_ready", bus.s1_ready, 0);
        chk("rst_w_en", bus.rf_w_en, 0);
        chk("rst_addr", bus.rf_rd_addr, 0);
        chk("rst_data", bus.rf_w_data, 0);
        chk("rst_mask", bus.pending_mask, 0);
        chk("rst_idle", bus.idle, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rel_s0_ready", bus.s0_ready, 1);
        chk("rel_s1_ready", bus.s1_ready, 1);

        // Single isolated writes: queued -> output stage for one cycle -> committed.
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            base = vecs[i].src ? cnt1 : cnt0;
            load(vecs[i].src, vecs[i].rd, vecs[i].data);
            wait_cnt(vecs[i].src, base + 1, 10);
            chk("vec_mask_queued", bus.pending_mask, vecs[i].exp_mask);
            chk("vec_idle_queued", bus.idle, 0);
            chk("vec_en_queued", bus.rf_w_en, 0);
            tick();
            chk("vec_en", bus.rf_w_en, vecs[i].exp_en);
            chk("vec_addr", bus.rf_rd_addr, vecs[i].rd);
            chk("vec_data", bus.rf_w_data, vecs[i].data);
            chk("vec_mask_out", bus.pending_mask, vecs[i].exp_mask);
            tick();
            chk("vec_en_after", bus.rf_w_en, 0);
            chk("vec_mask_after", bus.pending_mask, 0);
            chk("vec_idle_after", bus.idle, 1);
        end

        // Backpressure: s1 fills after two accepts, third payload waits for the first s1 pop.
        @(negedge clock);
        base = cnt1;
        for (int i = 1; i <= 3; i++) begin
            load(1'b0, 5'(i), 32'h0B00_0000 + i);
            load(1'b1, 5'(20 + i), 32'h0B10_0000 + i);
        end
        wait_cnt(1'b1, base + 2, 10);
        chk("bp_ready_low", bus.s1_ready, 0);
        chk("bp_valid_held", bus.s1_valid, 1);
        chk("bp_payload_held", bus.s1_rd_addr, 23);
        tick();
        chk("bp_ready_after_pop", bus.s1_ready, 1);
        chk("bp_not_yet", cnt1, base + 2);
        tick();
        chk("bp_third_accept", cnt1, base + 3);
        wait_drain(40);

        // Asynchronous reset with writes queued and one in the output stage.
        @(negedge clock);
        base = cnt0;
        load(1'b0, 5'd6, 32'h0000_0006);
        load(1'b0, 5'd7, 32'h0000_0007);
        load(1'b1, 5'd8, 32'h0000_0008);
        wait_cnt(1'b0, base + 2, 10);
        chk("mrst_pre_w_en", bus.rf_w_en, 1);
        reset_n = 1'b0;
        stim0.delete(); stim1.delete(); exp0.delete(); exp1.delete();
        #1;
        chk("mrst_w_en", bus.rf_w_en, 0);
        chk("mrst_mask", bus.pending_mask, 0);
        chk("mrst_s0_ready", bus.s0_ready, 0);
        chk("mrst_s1_ready", bus.s1_ready, 0);
        chk("mrst_idle", bus.idle, 1);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("mrst_rel_idle", bus.idle, 1);
        chk("mrst_rel_s0_ready", bus.s0_ready, 1);
        chk("mrst_rel_s1_ready", bus.s1_ready, 1);
        repeat (5) tick();
        chk("mrst_no_stale", bus.idle, 1);

        // Contention: strict alternation starting from source 0, one write per cycle.
        @(negedge clock);
        out_rd.delete(); out_cyc.delete();
        for (int i = 1; i <= 4; i++) begin
            load(1'b0, 5'(i), 32'h0000_0100 + i);
            load(1'b1, 5'(10 + i), 32'h0000_0200 + i);
        end
        wait_drain(60);
        chk("cont_count", out_rd.size(), 8);
        if (out_rd.size() == 8) begin
            for (int j = 0; j < 8; j++) chk("cont_order", out_rd[j], cont_exp[j]);
            chk("cont_back_to_back", out_cyc[7] - out_cyc[0], 7);
        end

        // Wrap-around: ten back-to-back writes on source 1.
        @(negedge clock);
        out_rd.delete(); out_cyc.delete();
        for (int i = 0; i < 10; i++) load(1'b1, 5'(20 + i), 32'hC000_0000 + i * 32'h11);
        wait_drain(80);
        chk("wrap_count", out_rd.size(), 10);
        if (out_rd.size() == 10) begin
            for (int j = 0; j < 10; j++) chk("wrap_order", out_rd[j], 20 + j);
            chk("wrap_back_to_back", out_cyc[9] - out_cyc[0], 9);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
